rs232_rx: RTL and testbench



---
 rtl/rs232_rx_if.sv | 25 ++
 rtl/rs232_rx.sv | 162 ++++++++++++++++
 tb/tb_rs232_rx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rs232_rx_if.sv
// rs232_rx_if: receiver result bundle (byte, strobe, error flags, busy).
// master = receiver drives; slave = consumer samples.
interface rs232_rx_if;
  logic [7:0] data;
  logic       data_ready;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (
    output data,
    output data_ready,
    output frame_err,
    output parity_err,
    output busy
  );

  modport slave (
    input data,
    input data_ready,
    input frame_err,
    input parity_err,
    input busy
  );
endinterface

// File: rtl/rs232_rx.sv
// rs232_rx: 8N1 serial receiver paced by an 8x oversampling strobe.
// Ports: inclk, rst (sync, active-high), tick8, rxd; rx = result bundle.
// Define RS232_RX_PARITY_EN for an even-parity bit between data and stop.
module rs232_rx #(
  parameter int OVS       = 8,
  parameter int DATA_BITS = 8
) (
  input  logic inclk,
  input  logic rst,
  input  logic tick8,
  input  logic rxd,
  rs232_rx_if.master rx
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;

  state_e               state_q, state_d;
  logic                 sync_q, rxs_q;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [2:0]           vote_q, vote_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [7:0]           data_q, data_d;
  logic                 rdy_q, rdy_d;
  logic                 ferr_q, ferr_d;
`ifdef RS232_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  function automatic logic maj3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic vote_full, vote_stop, last_tick;

  assign vote_full = maj3(vote_q[0], vote_q[1], vote_q[2]);
  // Stop decision is taken on the third sample tick itself,
  // so the live synchronized line stands in for vote_q[2].
  assign vote_stop = maj3(vote_q[0], vote_q[1], rxs_q);
  assign last_tick = (tcnt_q == TW'(OVS - 1));

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    vote_d  = vote_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    ferr_d  = ferr_q;
`ifdef RS232_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    if (tick8) begin
      if (state_q != IDLE) tcnt_d = tcnt_q + TW'(1);
      if (tcnt_q == TW'(3)) vote_d[0] = rxs_q;
      if (tcnt_q == TW'(4)) vote_d[1] = rxs_q;
      if (tcnt_q == TW'(5)) vote_d[2] = rxs_q;
      unique case (state_q)
        IDLE: begin
          if (!rxs_q) begin
            state_d = START;
            tcnt_d  = TW'(1);
          end
        end
        START: begin
          if (last_tick) begin
            state_d = vote_full ? IDLE : DATA;
            bcnt_d  = '0;
          end
        end
        DATA: begin
          if (last_tick) begin
            shreg_d = {vote_full, shreg_q[DATA_BITS-1:1]};
            if (bcnt_q == BW'(DATA_BITS - 1)) begin
`ifdef RS232_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end
        end
`ifdef RS232_RX_PARITY_EN
        PARITY: begin
          if (last_tick) begin
            par_d   = vote_full;
            state_d = STOP;
          end
        end
`endif
        STOP: begin
          // Leave mid-stop so a back-to-back start edge is caught.
          if (tcnt_q == TW'(5)) begin
            state_d = IDLE;
            rdy_d   = 1'b1;
            data_d  = shreg_q;
            ferr_d  = ~vote_stop;
`ifdef RS232_RX_PARITY_EN
            perr_d  = ^{shreg_q, par_q};
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge inclk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= 1'b1;
      rxs_q   <= 1'b1;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      vote_q  <= '1;
      shreg_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef RS232_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= rxd;
      rxs_q   <= sync_q;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      vote_q  <= vote_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
`ifdef RS232_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign rx.data       = data_q;
  assign rx.data_ready = rdy_q;
  assign rx.frame_err  = ferr_q;
  assign rx.busy       = (state_q != IDLE);
`ifdef RS232_RX_PARITY_EN
  assign rx.parity_err = perr_q;
`else
  assign rx.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: directed + random frames against a frame-level model.
// Ticks every 4 clocks, 32 clocks per bit.
module tb_rs232_rx;

  localparam int BIT = 32;
`ifdef RS232_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       busy;
  } rec_t;

  logic inclk = 1'b0;
  logic rst   = 1'b1;
  logic tick8 = 1'b0;
  logic rxd   = 1'b1;

  rs232_rx_if rif ();

  rs232_rx dut (
    .inclk (inclk),
    .rst   (rst),
    .tick8 (tick8),
    .rxd   (rxd),
    .rx    (rif)
  );

  int n_assert = 0;
  int n_fail   = 0;
  rec_t exp_q[$];
  rec_t got_q[$];
  logic [7:0] last_data = 8'h00;

  always #5 inclk = ~inclk;

  initial begin : tickgen
    int c;
    c = 0;
    forever begin
      @(negedge inclk);
      tick8 = (c == 0);
      c = (c + 1) % 4;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin : monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge inclk);
      if (prev) chk("pulse_width", {31'd0, rif.data_ready}, 32'd0);
      if (rif.data_ready)
        got_q.push_back({rif.data, rif.frame_err,
                         rif.parity_err, rif.busy});
      prev = rif.data_ready;
    end
  end

  function automatic rec_t model(input logic [7:0] b,
                                 input logic stop,
                                 input logic par);
    rec_t m;
    m.data = b;
    m.fe   = ~stop;
    m.pe   = PAR_EN & (^{b, par});
    m.busy = 1'b0;
    return m;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge inclk);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop,
                            input logic par);
    rxd = 1'b0;
    clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      clks(BIT);
    end
    if (PAR_EN) begin
      rxd = par;
      clks(BIT);
    end
    rxd = stop;
    clks(BIT);
    rxd = 1'b1;
    exp_q.push_back(model(b, stop, par));
  endtask

  task automatic check_frames(input string tag);
    int   budget;
    rec_t e, g;
    budget = 0;
    clks(64);
    while (got_q.size() < exp_q.size() && budget < 4000) begin
      clks(1);
      budget++;
    end
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_data"}, {24'd0, g.data}, {24'd0, e.data});
      chk({tag, "_fe"}, {31'd0, g.fe}, {31'd0, e.fe});
      chk({tag, "_pe"}, {31'd0, g.pe}, {31'd0, e.pe});
      chk({tag, "_busy"}, {31'd0, g.busy}, {31'd0, e.busy});
      last_data = e.data;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  function automatic logic par_for(input logic [7:0] b,
                                   input logic bad);
    return (^b) ^ bad;
  endfunction

  initial begin : main
    logic [7:0] b;
    logic       stop, bad;
    clks(4);
    chk("rst_data", {24'd0, rif.data}, 32'd0);
    chk("rst_ready", {31'd0, rif.data_ready}, 32'd0);
    chk("rst_fe", {31'd0, rif.frame_err}, 32'd0);
    chk("rst_pe", {31'd0, rif.parity_err}, 32'd0);
    chk("rst_busy", {31'd0, rif.busy}, 32'd0);
    rst = 1'b0;
    clks(40);

    send_frame(8'h55, 1'b1, par_for(8'h55, 1'b0));
    check_frames("f55");
    chk("idle_busy", {31'd0, rif.busy}, 32'd0);

    send_frame(8'hA3, 1'b1, par_for(8'hA3, 1'b0));
    send_frame(8'h0F, 1'b1, par_for(8'h0F, 1'b0));
    check_frames("b2b");

    rxd = 1'b0;
    clks(6);
    rxd = 1'b1;
    clks(80);
    chk("glitch_count", got_q.size(), 32'd0);
    chk("glitch_data", {24'd0, rif.data}, {24'd0, last_data});
    chk("glitch_busy", {31'd0, rif.busy}, 32'd0);

    send_frame(8'hFF, 1'b0, par_for(8'hFF, 1'b0));
    clks(64);
    send_frame(8'h12, 1'b1, par_for(8'h12, 1'b0));
    check_frames("ferr");

    for (int k = 0; k < 6; k++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      bad  = 1'($urandom_range(0, 1));
      send_frame(b, stop, par_for(b, bad));
      clks(stop ? $urandom_range(0, 40) : 64);
    end
    check_frames("rand");

    rxd = 1'b0;
    clks(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i] ^ b[i];
      rxd = (8'h3C >> i) & 8'h01 ? 1'b1 : 1'b0;
      clks(BIT);
    end
    rxd = 1'b1;
    clks(BIT / 2);
    chk("mid_busy", {31'd0, rif.busy}, 32'd1);
    rst = 1'b1;
    clks(1);
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, rif.busy}, 32'd0);
    chk("mid_rst_data", {24'd0, rif.data}, 32'd0);
    chk("mid_rst_ready", {31'd0, rif.data_ready}, 32'd0);
    clks(BIT * 8);
    chk("mid_rst_nopulse", got_q.size(), 32'd0);
    send_frame(8'h81, 1'b1, par_for(8'h81, 1'b0));
    check_frames("f81");

`ifdef RS232_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    check_frames("par");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
